// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock through a single shared subtractor.
// Start/busy/done handshake; results hold until the next accepted start or reset.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_nxt, r_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The partial remainder always stays below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit for the sign of the subtraction.
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = shifted[WIDTH-1:0];
      q_nxt = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        S_RUN: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Multi-cycle unsigned divider. It is the inverse companion to the combinational 8-bit multiplier in the ALU datapath and lets the ALU offer divide and modulo without a large combinational array. It uses a radix-2 restoring algorithm with one shared WIDTH+1-bit subtractor, one quotient bit per clock, and a start/busy/done handshake toward the ALU control.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse; results valid in that cycle
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  set with done when the captured divisor == 0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0. Reset wins over every other event, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0:
  - capture operands into internal registers: dividend shift register Q, divisor register D, partial remainder R = 0 (WIDTH+1 bits);
  - clear div_by_zero;
  - if divisor==0: go to DONE, set quotient = all ones, remainder = dividend, div_by_zero=1;
  - otherwise: go to RUN with counter=0.
- IDLE with start=0: stay in IDLE, outputs hold.
- RUN, once per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D};
  - if T is non-negative (MSB=0): R=T, shift 1 into Q;
  - else: R={R[WIDTH-1:0], Q[WIDTH-1]}, shift 0 into Q;
  - counter increments. On the edge where counter==WIDTH-1, perform the final iteration, load quotient/remainder from the post-iteration Q/R, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - divisor != 0: WIDTH RUN edges after E0, so done is high in the cycle after edge E0+WIDTH.
  - divisor == 0: done is high in the cycle after E0.
- busy=1 exactly in RUN cycles; busy and done are never high together.
- start while in RUN or DONE is ignored; there is no queueing. Operand changes after E0 have no effect.
- quotient, remainder and div_by_zero hold their last values until the next accepted start or reset. They are not cleared on return to IDLE.
- Arithmetic is fully unsigned. Invariant for divisor != 0: dividend == quotient*divisor + remainder, and remainder < divisor.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then dividend=200, divisor=7, start 1 cycle -> busy high 8 cycles, then done=1 one cycle with quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5. Both take the full 8-cycle latency.
- dividend=100, divisor=0 -> done in the cycle after E0 with no busy cycle; quotient=255, remainder=100, div_by_zero=1. Next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Start 200/7, then at RUN cycle 3 assert start with 10/2 and change the operand inputs -> result still 28/4 with done at the normal cycle; the 10/2 request is not executed.
- Start 200/7, assert rst at RUN cycle 4 -> next cycle busy=0, done=0, outputs 0, state IDLE. A following 50/6 gives quotient=8, remainder=2.
- Exhaustive sweep of all 65536 operand pairs (WIDTH=8), back-to-back with start asserted in the first IDLE cycle -> every result matches a reference / and %, and divisor=0 cases match the rule above.
